// File: rtl/in_pass4_debounce.sv
// ---------------------------------------------------------------------------
// in_pass4_debounce
//
// Four-channel input conditioner for the InPass4 pad outputs. Each channel
// brings its asynchronous pad value into the CLK domain through a plain flop
// chain. It then debounces the value with a stable-cycle counter. It produces
// a clean level, single-cycle rise/fall pulses and a sticky event flag that
// can be cleared per channel.
//
// Parameters
//   SYNC_STAGES : synchroniser depth per channel (2..4)
//   DEB_CYCLES  : consecutive differing evaluations needed before the
//                 debounced level follows the input (1..255, 1 = no filtering)
//
// Ports
//   CLK     in   fabric clock, all state changes on its rising edge
//   RST     in   synchronous active-high reset, clears every flop
//   pin_i   in   [3:0] raw pad values (asynchronous to CLK)
//   clr_i   in   [3:0] per-channel sticky event clear
//   level_o out  [3:0] debounced level
//   rise_o  out  [3:0] one-cycle pulse on a debounced 0->1
//   fall_o  out  [3:0] one-cycle pulse on a debounced 1->0
//   event_o out  [3:0] sticky flag, set by any debounced edge
// ---------------------------------------------------------------------------
module in_pass4_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] pin_i,
  input  logic [3:0] clr_i,
  output logic [3:0] level_o,
  output logic [3:0] rise_o,
  output logic [3:0] fall_o,
  output logic [3:0] event_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic                   event_q, event_d;
      logic                   s;

      // Bit 0 is the first synchroniser stage; the top bit is the
      // synchronised value the debouncer looks at.
      assign s = sync_q[SYNC_STAGES-1];

      always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i[gi]};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (s == level_q) begin
          // Input agrees with the output: any partial qualification is void.
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          // This evaluation completes DEB_CYCLES in a row of disagreement.
          level_d = s;
          cnt_d   = '0;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        // A new edge beats a coincident clear so no event is ever lost.
        event_d = (event_q & ~clr_i[gi]) | rise_d | fall_d;
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          sync_q  <= '0;
          cnt_q   <= '0;
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          event_q <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
          event_q <= event_d;
        end
      end

      assign level_o[gi] = level_q;
      assign rise_o[gi]  = rise_q;
      assign fall_o[gi]  = fall_q;
      assign event_o[gi] = event_q;
    end
  endgenerate

endmodule

// File: tb/tb_in_pass4_debounce.sv
// ---------------------------------------------------------------------------
// Testbench for in_pass4_debounce (default parameters).
// A table of hand-computed vectors covers reset and clean edges.
// Short hand-written sequences cover glitch, bounce, sticky clear and
// reset mid-count.
// A randomized run is compared against a behavioural model. The model holds
// the pin history as a delay-line queue and a window of the last DEB_CYCLES
// synchronised samples.
// ---------------------------------------------------------------------------
module tb_in_pass4_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       CLK;
  logic       RST;
  logic [3:0] pin_i;
  logic [3:0] clr_i;
  logic [3:0] level_o, rise_o, fall_o, event_o;

  int n_tests = 0;
  int n_fail  = 0;

  in_pass4_debounce #(
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .pin_i  (pin_i),
    .clr_i  (clr_i),
    .level_o(level_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .event_o(event_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural reference model ----------------
  logic [3:0] pipe_q[$];   // pin samples still in flight to the debouncer
  logic [3:0] win_q[$];    // last DEB synchronised samples seen by it
  logic [3:0] m_level, m_rise, m_fall, m_event;

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < SYNC; i++) pipe_q.push_back(4'h0);
    win_q.delete();
    m_level = 4'h0;
    m_rise  = 4'h0;
    m_fall  = 4'h0;
    m_event = 4'h0;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] pin, input logic [3:0] clr);
    logic [3:0] s;
    logic [3:0] chg;
    if (rst) begin
      model_reset();
    end else begin
      s = pipe_q.pop_front();
      pipe_q.push_back(pin);
      win_q.push_back(s);
      if (win_q.size() > DEB) void'(win_q.pop_front());
      chg = 4'h0;
      // A channel moves when every one of the last DEB samples disagrees.
      if (win_q.size() == DEB) begin
        for (int ch = 0; ch < 4; ch++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (win_q[k]) if (win_q[k][ch] == m_level[ch]) all_diff = 1'b0;
          chg[ch] = all_diff;
        end
      end
      m_rise  = chg & ~m_level;
      m_fall  = chg & m_level;
      m_level = m_level ^ chg;
      m_event = (m_event & ~clr) | chg;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick(input logic rst, input logic [3:0] pin, input logic [3:0] clr);
    RST   = rst;
    pin_i = pin;
    clr_i = clr;
    @(posedge CLK);
    model_step(rst, pin, clr);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic do_reset();
    tick(1'b1, 4'h0, 4'h0);
    tick(1'b1, 4'h0, 4'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] pin;
    logic [3:0] clr;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] evt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    RST   = 1'b1;
    pin_i = 4'h0;
    clr_i = 4'h0;
    model_reset();

    // Pins high through reset, then release.
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    for (int e = 1; e <= 5; e++) vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF});
    for (int e = 7; e <= 10; e++) vecs.push_back('{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF});
    // Channel 0 falls; fall pulse six edges after it is first sampled.
    for (int e = 1; e <= 5; e++) vecs.push_back('{1'b0, 4'hE, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF});
    vecs.push_back('{1'b0, 4'hE, 4'h0, 4'hE, 4'h0, 4'h1, 4'hF});
    vecs.push_back('{1'b0, 4'hE, 4'h0, 4'hE, 4'h0, 4'h0, 4'hF});

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].pin, vecs[i].clr);
      check("vec level", i, level_o, vecs[i].level);
      check("vec rise",  i, rise_o,  vecs[i].rise);
      check("vec fall",  i, fall_o,  vecs[i].fall);
      check("vec event", i, event_o, vecs[i].evt);
    end

    // Glitch: channel 1 high for three cycles only.
    do_reset();
    for (int t = 1; t <= 14; t++) begin
      tick(1'b0, (t <= 3) ? 4'h2 : 4'h0, 4'h0);
      check("glitch ch1", t, {level_o[1], rise_o[1], fall_o[1], event_o[1]}, 4'h0);
    end

    // Bounce on channel 2: 1,1,0,1,0,0,1 then held high.
    do_reset();
    begin
      logic [6:0] bounce;
      bounce = 7'b1001011;   // bit t-1 is the pin value on tick t
      for (int t = 1; t <= 16; t++) begin
        tick(1'b0, (t <= 7) ? {1'b0, bounce[t-1], 2'b00} : 4'h4, 4'h0);
        check("bounce rise", t, {3'b000, rise_o[2]}, (t == 12) ? 4'h1 : 4'h0);
        check("bounce level", t, {3'b000, level_o[2]}, (t >= 12) ? 4'h1 : 4'h0);
      end
    end

    // Sticky clear on channel 3 with channel 0 as an untouched bystander.
    do_reset();
    for (int t = 1; t <= 19; t++) begin
      logic [3:0] p;
      p = (t >= 7 && t <= 12) ? 4'h1 : 4'h9;
      tick(1'b0, p, (t >= 18) ? 4'h8 : 4'h0);
      if (t == 6)  check("sticky first set", t, event_o, 4'h9);
      if (t == 12) check("sticky fall keeps", t, {fall_o[3], event_o[3], 2'b00}, 4'hC);
      if (t == 18) begin
        check("sticky set wins rise", t, rise_o, 4'h8);
        check("sticky set wins evt", t, event_o, 4'h9);
      end
      if (t == 19) check("sticky clear", t, event_o, 4'h1);
    end

    // Reset mid-count on channel 0.
    do_reset();
    for (int t = 1; t <= 12; t++) begin
      tick(t == 4, 4'h1, 4'h0);
      check("midrst rise", t, rise_o, (t == 10) ? 4'h1 : 4'h0);
      if (t == 4) check("midrst level", t, level_o, 4'h0);
    end

    // Randomized run against the model.
    do_reset();
    begin
      logic [3:0] p;
      p = 4'h0;
      for (int t = 0; t < 3000; t++) begin
        logic [3:0] c;
        logic       r;
        for (int ch = 0; ch < 4; ch++) if ($urandom_range(0, 5) == 0) p[ch] = ~p[ch];
        c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        r = ($urandom_range(0, 149) == 0);
        tick(r, p, c);
        check("rnd level", t, level_o, m_level);
        check("rnd rise",  t, rise_o,  m_rise);
        check("rnd fall",  t, fall_o,  m_fall);
        check("rnd event", t, event_o, m_event);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/in_pass4_debounce.md
Name: in_pass4_debounce

Overview:
- Four-channel input conditioning stage placed directly downstream of the InPass4 pad primitive. Consumes its O0..O3 outputs.
- Per channel:
  - synchronises the asynchronous pad value into CLK;
  - debounces it with a stable-cycle counter;
  - produces a clean level, one-cycle rise/fall pulses and a sticky event flag with per-channel clear.
- Feeds user fabric logic (counters, FSMs) that must not see metastable or bouncing pad inputs.

Parameters:
- SYNC_STAGES, 2, synchroniser flop depth per channel. Legal values are 2..4.
- DEB_CYCLES, 4, consecutive stable cycles required before the debounced level changes. Legal values are 1..255. 1 means no filtering.
- CNT_W, derived localparam = clog2(DEB_CYCLES+1), per-channel counter width.

Ports:
- CLK  input  1  fabric clock. All state updates on its rising edge.
- RST  input  1  synchronous reset, active-high.
- pin_i  input  4  raw pad values from InPass4 O3..O0. Asynchronous to CLK.
- clr_i  input  4  per-channel sticky event clear, sampled on CLK.
- level_o  output  4  debounced level.
- rise_o  output  4  one-cycle pulse on debounced 0->1.
- fall_o  output  4  one-cycle pulse on debounced 1->0.
- event_o  output  4  sticky flag, set by any debounced edge.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - All synchroniser flops, counters, level_o, rise_o, fall_o and event_o go to 0.
  - RST takes priority over all other activity.
  - RST has no asynchronous effect.
- Synchroniser:
  - pin_i[n] passes through an SYNC_STAGES-deep flop chain.
  - s[n] is the last stage output.
  - No logic between stages.
- Debounce, per channel n, evaluated each edge with RST=0:
  - If s[n] == level_o[n]: cnt[n] <= 0.
  - Else if cnt[n] == DEB_CYCLES-1: level_o[n] <= s[n] and cnt[n] <= 0.
  - Else: cnt[n] <= cnt[n]+1.
  - Counter never wraps. The maximum value reached is DEB_CYCLES-1.
- Latency:
  - Count the edge that first samples a new stable pin value as edge 1.
  - level_o changes on edge SYNC_STAGES+DEB_CYCLES.
  - Default parameters: edge 6.
- Glitch rejection:
  - A pin excursion that leaves s[n] differing for fewer than DEB_CYCLES consecutive evaluations resets cnt[n] and produces no output change.
  - A bounce restarts the count from 0.
- Edge pulses:
  - rise_o[n] / fall_o[n] are registered and assert on the same edge level_o[n] updates.
  - They are high for exactly one cycle.
  - They are never both high.
- Sticky event:
  - event_o[n] <= (event_o[n] & ~clr_i[n]) | rise_or_fall_update[n].
  - If set and clear coincide on the same edge, set wins.
  - clr_i on a channel with no pending edge clears on the next edge.
- Independence: channels are fully independent. Simultaneous edges on several channels are all reported on the same cycle.
- Reset mid-count:
  - Pending counts are discarded.
  - After release, a pin still differing from 0 re-qualifies from scratch with full latency.
  - No pulse may be emitted during or on the edge of reset.
- Pin held high through reset: after release, level_o rises with a rise_o pulse on edge SYNC_STAGES+DEB_CYCLES after release. This is intended; software clears event_o.

Test Plan:
1. Reset: pin_i=4'hF held while RST=1 for 5 cycles -> all outputs 0 during reset. After release (defaults), level_o=4'hF, rise_o=4'hF for exactly one cycle, and event_o=4'hF, all on edge 6.
2. Clean edge (defaults): pin_i[0] 0->1 sampled at edge 1 -> level_o[0]=1 and rise_o[0]=1 at edge 6. rise_o[0] returns to 0 at edge 7. Later 1->0 gives fall_o[0] six edges after sampling.
3. Glitch: pin_i[1] high for 3 cycles then low (DEB_CYCLES=4) -> level_o[1], rise_o[1], fall_o[1] and event_o[1] stay 0 throughout.
4. Bounce: pin_i[2] sequence 1,1,0,1,0,0,1 then held high -> single rise_o[2] pulse 6 edges after the final 0->1 sample. No intermediate pulses.
5. Sticky clear: event_o[3]=1, clr_i[3]=1 on the same edge as a new rise_o[3] -> event_o[3] stays 1. clr_i[3]=1 alone next cycle -> event_o[3]=0. Other channels unaffected.
6. Reset mid-count: pin_i[0] high, RST pulsed on edge 4 -> no rise_o[0] at edge 6. rise_o[0] occurs on edge 6 after RST release (DEB_CYCLES=4, SYNC_STAGES=2), i.e. full latency restarts.
